instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- Upstream neighbour of the single-cycle controller/datapath.
- Owns the PC and issues word fetches to an instruction memory with variable latency. Delivers one instruction per cycle, plus its PC+4, through a registered output slot.
- The slot is backed by a one-entry skid buffer, so downstream stalls never drop a fetched word.
- Applies branch, jump and jump-register redirects, and squashes any wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_WORD, 32'h0000_0000, value driven on Instruction whenever InstrValid=0.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  downstream cannot consume the current output this cycle.
- BranchTaken  in  1  the current output instruction is a taken conditional branch.
- BranchOffset  in  32  sign-extended 16-bit immediate of that branch (word offset).
- Jump  in  1  the current output instruction is a jump.
- JumpSel  in  1  0 = J/JAL immediate target, 1 = JR register target.
- JumpTarget  in  26  instr[25:0] for J/JAL.
- JumpRegAddr  in  32  rs value for JR.
- IMemReq  out  1  fetch request.
- IMemAddr  out  32  word-aligned fetch address.
- IMemReady  in  1  response valid; completes the outstanding request.
- IMemRData  in  32  fetched word.
- Instruction  out  32  instruction presented to the controller.
- NextInstruct  out  32  PC+4 of Instruction (JAL link value).
- PCOut  out  32  address of Instruction.
- InstrValid  out  1  Instruction is real (not a bubble).

Behaviour:
- Reset (Reset=0, asynchronous):
  - IMemReq=0, InstrValid=0, Instruction=NOP_WORD, NextInstruct=0, PCOut=0.
  - Skid buffer empty, fetch PC=RESET_PC, state=FETCH.
  - The first request is issued on the first cycle after Reset rises.
- Memory protocol:
  - At most one outstanding request.
  - Once IMemReq=1, IMemReq and IMemAddr stay stable until the cycle IMemReady=1.
  - IMemReady in the same cycle as the request is legal (zero wait states gives 1 instr/cycle).
- Consume = InstrValid & ~Stall. Redirect inputs are sampled only on a consume cycle and are ignored otherwise.
- Redirect target:
  - Jump & JumpSel=0: {NextInstruct[31:28], JumpTarget, 2'b00}.
  - Jump & JumpSel=1: JumpRegAddr, with bits [1:0] forced to 0.
  - Else BranchTaken: NextInstruct + (BranchOffset<<2), modulo 2^32.
  - Jump has priority over BranchTaken.
- States:
  - FETCH:
    - IMemReq=1, IMemAddr=reqPC.
    - On IMemReady with the output slot free or consumed this cycle: load the output slot {word, reqPC, reqPC+4, valid}; PC advances by 4.
    - On IMemReady with the output slot full and not consumed: load the skid buffer, PC advances by 4, go to HOLD.
    - An empty output slot that is consumed or not refilled shows InstrValid=0.
  - HOLD:
    - IMemReq=0.
    - On consume: skid buffer moves to the output slot, then go to FETCH.
  - KILL:
    - IMemReq=1 on the stale address.
    - On IMemReady: drop the word, go to FETCH at the redirect PC.
- Redirect on a consume cycle:
  - Next cycle InstrValid=0 and the skid buffer is cleared. PC is set to the target.
  - If a request is outstanding and IMemReady=0 this cycle, go to KILL. Otherwise go to FETCH at the target; a response arriving in the redirect cycle is discarded.
  - Minimum redirect penalty is one bubble cycle.
- Ordering: delivered PCs are strictly sequential (+4) except immediately after a redirect. No word is duplicated or lost under any Stall pattern.
- PC wraps from 32'hFFFF_FFFC to 0 with no error.
- Reset asserted mid-request returns to the reset state immediately. No response is awaited.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs FetchCount[31:0] and SquashCount[31:0], both reset to 0 and wrapping.
  - FetchCount increments on each consume.
  - SquashCount increments on each word dropped: the killed in-flight response, a cleared skid entry, or a response arriving in the redirect cycle.
- Undefined: the ports and counters do not exist.

Test Plan:
- Reset release, IMemReady tied 1, words = address: IMemAddr 0,4,8,… on consecutive cycles; Instruction 0,4,8 with NextInstruct 4,8,12; InstrValid=1 from cycle 2.
- Stall=1 for 3 cycles while a response arrives: IMemReq drops in HOLD; after release, the output sequence is 0x10,0x14,0x18 with no gap, duplicate or loss.
- Instr at 0x10 consumed with BranchTaken=1, BranchOffset=3, memory latency 2: the in-flight 0x14 fetch is killed; next valid Instruction has PCOut=0x20; InstrValid=0 for the kill+refetch cycles.
- J with JumpTarget=26'h40 at PC 0x8: next PCOut=0x100. JR with JumpRegAddr=0x203: next PCOut=0x200. Jump and BranchTaken together: jump target wins.
- Redirect asserted while Stall=1: ignored, and the PC sequence is unchanged.
- Reset pulled low while IMemReq=1 and waiting: IMemReq=0 and InstrValid=0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches from a variable-latency instruction memory,
// delivers one instruction per cycle through a registered slot with a one-entry skid buffer,
// and applies branch/jump/jump-register redirects. Define IF_PERF_CNT_EN to add fetch/squash counters.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchOffset,
    input  logic        Jump,
    input  logic        JumpSel,
    input  logic [25:0] JumpTarget,
    input  logic [31:0] JumpRegAddr,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemRData,
    output logic [31:0] Instruction,
    output logic [31:0] NextInstruct,
    output logic [31:0] PCOut,
    output logic        InstrValid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] SquashCount
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_KILL  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        started_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_npc_q, out_npc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_valid_q, skid_valid_d;

    logic        req;
    logic        resp;
    logic        consume;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [1:0]  squash_inc;

    // started_q holds off the first request until the cycle after reset is released.
    assign req      = started_q && (state_q != ST_HOLD);
    assign resp     = req && IMemReady;
    assign consume  = out_valid_q && !Stall;
    assign redirect = consume && (Jump || BranchTaken);
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        target = out_npc_q + {BranchOffset[29:0], 2'b00};
        if (Jump) begin
            if (JumpSel) begin
                target = {JumpRegAddr[31:2], 2'b00};
            end else begin
                target = {out_npc_q[31:28], JumpTarget, 2'b00};
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_npc_d    = out_npc_q;
        out_valid_d  = out_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        squash_inc   = 2'd0;

        if (redirect) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            squash_inc   = {1'b0, skid_valid_q} + {1'b0, resp};
            // An unanswered request must still complete at its original address.
            if (req && !IMemReady) begin
                state_d = ST_KILL;
                tgt_d   = target;
            end else begin
                state_d = ST_FETCH;
                pc_d    = target;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (resp) begin
                        pc_d = pc_plus4;
                        if (!out_valid_q || consume) begin
                            out_instr_d = IMemRData;
                            out_pc_d    = pc_q;
                            out_npc_d   = pc_plus4;
                            out_valid_d = 1'b1;
                        end else begin
                            skid_instr_d = IMemRData;
                            skid_pc_d    = pc_q;
                            skid_valid_d = 1'b1;
                            state_d      = ST_HOLD;
                        end
                    end else if (consume) begin
                        out_valid_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (consume) begin
                        out_instr_d  = skid_instr_q;
                        out_pc_d     = skid_pc_q;
                        out_npc_d    = skid_pc_q + 32'd4;
                        out_valid_d  = 1'b1;
                        skid_valid_d = 1'b0;
                        state_d      = ST_FETCH;
                    end
                end
                ST_KILL: begin
                    if (consume) begin
                        out_valid_d = 1'b0;
                    end
                    if (resp) begin
                        squash_inc = 2'd1;
                        pc_d       = tgt_q;
                        state_d    = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_FETCH;
            started_q    <= 1'b0;
            pc_q         <= RESET_PC;
            tgt_q        <= RESET_PC;
            out_instr_q  <= NOP_WORD;
            out_pc_q     <= 32'd0;
            out_npc_q    <= 32'd0;
            out_valid_q  <= 1'b0;
            skid_instr_q <= NOP_WORD;
            skid_pc_q    <= 32'd0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            started_q    <= 1'b1;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_npc_q    <= out_npc_d;
            out_valid_q  <= out_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign IMemReq      = req;
    assign IMemAddr     = pc_q;
    assign Instruction  = out_valid_q ? out_instr_q : NOP_WORD;
    assign NextInstruct = out_npc_q;
    assign PCOut        = out_pc_q;
    assign InstrValid   = out_valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] squash_cnt_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fetch_cnt_q  <= 32'd0;
            squash_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_q + {31'd0, consume};
            squash_cnt_q <= squash_cnt_q + {30'd0, squash_inc};
        end
    end

    assign FetchCount  = fetch_cnt_q;
    assign SquashCount = squash_cnt_q;

    logic unused_bits;
    assign unused_bits = ^{BranchOffset[31:30], JumpRegAddr[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{BranchOffset[31:30], JumpRegAddr[1:0], squash_inc};
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed self-checking bench for instruction_fetch_stage with a variable-latency memory model
// whose fetched word is the address XOR a fixed key.
module tb_instruction_fetch_stage;

    localparam logic [31:0] KEY = 32'hA500_0000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchOffset = 32'd0;
    logic        Jump = 1'b0;
    logic        JumpSel = 1'b0;
    logic [25:0] JumpTarget = 26'd0;
    logic [31:0] JumpRegAddr = 32'd0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemRData;
    logic [31:0] Instruction;
    logic [31:0] NextInstruct;
    logic [31:0] PCOut;
    logic        InstrValid;

    instruction_fetch_stage dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchOffset (BranchOffset),
        .Jump         (Jump),
        .JumpSel      (JumpSel),
        .JumpTarget   (JumpTarget),
        .JumpRegAddr  (JumpRegAddr),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemReady    (IMemReady),
        .IMemRData    (IMemRData),
        .Instruction  (Instruction),
        .NextInstruct (NextInstruct),
        .PCOut        (PCOut),
        .InstrValid   (InstrValid)
    );

    always #5 Clk = ~Clk;

    // Memory model: answers after lat cycles of a held request (lat=0 answers the same cycle).
    int lat = 0;
    int mem_cnt;
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) mem_cnt <= 0;
        else if (IMemReq && IMemReady) mem_cnt <= 0;
        else if (IMemReq) mem_cnt <= mem_cnt + 1;
    end
    assign IMemReady = IMemReq && (mem_cnt >= lat);
    assign IMemRData = IMemAddr ^ KEY;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    logic [31:0] log_pc[$];
    logic [31:0] log_ins[$];
    logic [31:0] log_npc[$];
    logic [31:0] exp_pc[$];

    always @(negedge Clk) begin
        if (Reset && InstrValid && !Stall) begin
            log_pc.push_back(PCOut);
            log_ins.push_back(Instruction);
            log_npc.push_back(NextInstruct);
            $display("consume pc=%08h instr=%08h next=%08h", PCOut, Instruction, NextInstruct);
        end
    end

    // A pending request must keep IMemReq and IMemAddr stable until answered.
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    always @(negedge Clk) begin
        if (!Reset) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                check_eq("req_hold", {31'd0, IMemReq}, 32'd1);
                check_eq("addr_hold", IMemAddr, pend_addr);
            end
            pend      <= IMemReq && !IMemReady;
            pend_addr <= IMemAddr;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_redirect();
        BranchTaken  = 1'b0;
        BranchOffset = 32'd0;
        Jump         = 1'b0;
        JumpSel      = 1'b0;
        JumpTarget   = 26'd0;
        JumpRegAddr  = 32'd0;
    endtask

    task automatic do_reset(input int l);
        Reset = 1'b0;
        Stall = 1'b0;
        clear_redirect();
        lat = l;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        log_pc.delete();
        log_ins.delete();
        log_npc.delete();
        exp_pc.delete();
        Reset = 1'b1;
    endtask

    task automatic wait_pc(input logic [31:0] pc, input string tag);
        int n = 0;
        while (!(InstrValid && PCOut == pc) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check_eq({tag, "_timeout"}, PCOut, pc);
    endtask

    task automatic compare_log(input string tag);
        check_eq({tag, "_len"}, {31'd0, log_pc.size() >= exp_pc.size()}, 32'd1);
        for (int i = 0; i < exp_pc.size(); i++) begin
            if (i < log_pc.size()) begin
                check_eq($sformatf("%s_pc%0d", tag, i), log_pc[i], exp_pc[i]);
                check_eq($sformatf("%s_ins%0d", tag, i), log_ins[i], exp_pc[i] ^ KEY);
                check_eq($sformatf("%s_npc%0d", tag, i), log_npc[i], exp_pc[i] + 32'd4);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bub;
        logic found;

        // Phase A: reset state, zero-wait streaming, stall with skid
        lat = 0;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check_eq("rst_req", {31'd0, IMemReq}, 32'd0);
        check_eq("rst_valid", {31'd0, InstrValid}, 32'd0);
        check_eq("rst_instr", Instruction, 32'd0);
        check_eq("rst_npc", NextInstruct, 32'd0);
        check_eq("rst_pc", PCOut, 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        log_pc.delete(); log_ins.delete(); log_npc.delete();
        step();
        check_eq("c1_req", {31'd0, IMemReq}, 32'd1);
        check_eq("c1_addr", IMemAddr, 32'h0);
        check_eq("c1_valid", {31'd0, InstrValid}, 32'd0);
        step();
        check_eq("c2_valid", {31'd0, InstrValid}, 32'd1);
        check_eq("c2_pc", PCOut, 32'h0);
        check_eq("c2_instr", Instruction, KEY);
        check_eq("c2_npc", NextInstruct, 32'h4);
        check_eq("c2_addr", IMemAddr, 32'h4);
        step();
        check_eq("c3_pc", PCOut, 32'h4);
        check_eq("c3_addr", IMemAddr, 32'h8);
        wait_pc(32'h10, "a_wait10");
        Stall = 1'b1;
        step();
        check_eq("hold_req1", {31'd0, IMemReq}, 32'd0);
        check_eq("hold_pc1", PCOut, 32'h10);
        step();
        check_eq("hold_req2", {31'd0, IMemReq}, 32'd0);
        step();
        Stall = 1'b0;
        wait_pc(32'h20, "a_wait20");
        for (int a = 0; a < 32'h20; a += 4) exp_pc.push_back(a);
        compare_log("seqA");

        // Phase B: branch kills an in-flight fetch (latency 2)
        do_reset(2);
        wait_pc(32'h10, "b_wait10");
        BranchTaken  = 1'b1;
        BranchOffset = 32'd3;
        check_eq("kill_not_ready", {31'd0, IMemReady}, 32'd0);
        step();
        clear_redirect();
        check_eq("kill_valid", {31'd0, InstrValid}, 32'd0);
        check_eq("kill_req", {31'd0, IMemReq}, 32'd1);
        check_eq("kill_addr", IMemAddr, 32'h14);
        bub = 0;
        while (!InstrValid && bub < 50) begin
            bub++;
            step();
        end
        check_eq("kill_bubbles", bub, 32'd5);
        check_eq("kill_newpc", PCOut, 32'h20);
        step();
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h20};
        compare_log("seqB");

        // Phase C: J, JR, jump-over-branch priority, PC wrap
        do_reset(0);
        wait_pc(32'h8, "c_wait8");
        Jump = 1'b1; JumpSel = 1'b0; JumpTarget = 26'h40;
        step();
        clear_redirect();
        check_eq("j_bubble", {31'd0, InstrValid}, 32'd0);
        wait_pc(32'h104, "c_wait104");
        Jump = 1'b1; JumpSel = 1'b1; JumpRegAddr = 32'h203;
        step();
        clear_redirect();
        wait_pc(32'h204, "c_wait204");
        Jump = 1'b1; JumpSel = 1'b1; JumpRegAddr = 32'h300;
        BranchTaken = 1'b1; BranchOffset = 32'd1;
        step();
        clear_redirect();
        wait_pc(32'h300, "c_wait300");
        Jump = 1'b1; JumpSel = 1'b1; JumpRegAddr = 32'hFFFF_FFF8;
        step();
        clear_redirect();
        wait_pc(32'h4, "c_wait4");
        step();
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h200, 32'h204, 32'h300,
                   32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        compare_log("seqC");

        // Phase D: redirect under stall ignored; redirect from HOLD clears skid
        do_reset(0);
        wait_pc(32'h8, "d_wait8");
        Stall = 1'b1;
        BranchTaken = 1'b1; BranchOffset = 32'h40;
        Jump = 1'b1; JumpTarget = 26'h80;
        step();
        Stall = 1'b0;
        clear_redirect();
        wait_pc(32'h10, "d_wait10");
        Stall = 1'b1;
        step();
        Stall = 1'b0;
        BranchTaken = 1'b1; BranchOffset = 32'd4;
        step();
        clear_redirect();
        wait_pc(32'h28, "d_wait28");
        step();
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h24, 32'h28};
        compare_log("seqD");

        // Phase E: reset while a request waits
        do_reset(1);
        wait_pc(32'h8, "e_wait8");
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (IMemReq && !IMemReady) found = 1'b1;
            else step();
        end
        check_eq("e_pending", {31'd0, found}, 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check_eq("mid_rst_req", {31'd0, IMemReq}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, InstrValid}, 32'd0);
        check_eq("mid_rst_instr", Instruction, 32'd0);
        check_eq("mid_rst_pc", PCOut, 32'd0);
        check_eq("mid_rst_npc", NextInstruct, 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        log_pc.delete(); log_ins.delete(); log_npc.delete();
        step();
        check_eq("restart_req", {31'd0, IMemReq}, 32'd1);
        check_eq("restart_addr", IMemAddr, 32'h0);
        wait_pc(32'h4, "e_wait4");
        step();
        exp_pc = '{32'h0, 32'h4};
        compare_log("seqE");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
